// File: rtl/delta_decoder_pkg.sv
// Shared types and defaults for the delta decoder; also read by the encoder side.
package delta_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned STEP_MIN_DEF = 1;
  localparam int unsigned STEP_MAX_DEF = 16;
  localparam int unsigned RUN_LEN_DEF  = 3;
  localparam int unsigned DECIM_DEF    = 4;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/delta_decoder_step_adapt.sv
// Adaptive step size: doubles after RUN_LEN equal bits, halves on every bit change.
module delta_step_adapt
  import delta_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned STEP_MIN = STEP_MIN_DEF,
  parameter int unsigned STEP_MAX = STEP_MAX_DEF,
  parameter int unsigned RUN_LEN  = RUN_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             bit_in,
  output logic [WIDTH-1:0] step
);

  localparam int unsigned RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0]    RUN_FULL  = RW'(RUN_LEN);
  localparam logic [RW-1:0]    RUN_ONE   = RW'(1);
  localparam logic [WIDTH-1:0] S_MIN     = WIDTH'(STEP_MIN);
  localparam logic [WIDTH-1:0] S_MAX     = WIDTH'(STEP_MAX);
  localparam logic [WIDTH-1:0] S_HALFMAX = WIDTH'(STEP_MAX / 2);

  logic [WIDTH-1:0] step_q, step_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;

  always_comb begin
    step_d     = step_q;
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    if (accept) begin
      last_bit_d = bit_in;
      if (bit_in == last_bit_q) begin
        if (run_cnt_q < RUN_FULL) begin
          run_cnt_d = run_cnt_q + RUN_ONE;
        end else begin
          run_cnt_d = RUN_FULL;
        end
        if (run_cnt_d == RUN_FULL) begin
          if (step_q >= S_HALFMAX) begin
            step_d = S_MAX;
          end else begin
            step_d = step_q << 1;
          end
        end else begin
          step_d = step_q;
        end
      end else begin
        run_cnt_d = RUN_ONE;
        if ((step_q >> 1) < S_MIN) begin
          step_d = S_MIN;
        end else begin
          step_d = step_q >> 1;
        end
      end
    end else begin
      step_d = step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= S_MIN;
      run_cnt_q  <= {RW{1'b0}};
      last_bit_q <= 1'b0;
    end else begin
      step_q     <= step_d;
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/delta_decoder.sv
// Delta-modulation decoder: saturating accumulator, decimation and valid/ready output.
// Define DELTA_ADAPTIVE_EN for adaptive step; otherwise the step is fixed at STEP_MIN.
module delta_decoder
  import delta_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned STEP_MIN = STEP_MIN_DEF,
  parameter int unsigned STEP_MAX = STEP_MAX_DEF,
  parameter int unsigned RUN_LEN  = RUN_LEN_DEF,
  parameter int unsigned DECIM    = DECIM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0]    DECIM_LAST = DW'(DECIM - 1);
  localparam logic [DW-1:0]    DECIM_ONE  = DW'(1);
  localparam logic [WIDTH-1:0] ACC_RST    = WIDTH'(midscale(WIDTH));

  logic [WIDTH-1:0] step_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             due_s;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [DW-1:0]    decim_q, decim_d;
  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] sample_data_q, sample_data_d;
  logic             overrun_q, overrun_d;

`ifdef DELTA_ADAPTIVE_EN
  delta_step_adapt #(
    .WIDTH   (WIDTH),
    .STEP_MIN(STEP_MIN),
    .STEP_MAX(STEP_MAX),
    .RUN_LEN (RUN_LEN)
  ) u_step_adapt (
    .clk   (clk),
    .rst   (rst),
    .accept(bit_valid),
    .bit_in(bit_in),
    .step  (step_s)
  );
`else
  assign step_s = WIDTH'(STEP_MIN);
`endif

  // The carry/borrow bit of the WIDTH+1 result flags saturation in either direction.
  always_comb begin
    if (bit_in) begin
      sum_s = {1'b0, acc_q} + {1'b0, step_s};
      if (sum_s[WIDTH]) begin
        acc_next_s = {WIDTH{1'b1}};
      end else begin
        acc_next_s = sum_s[WIDTH-1:0];
      end
    end else begin
      sum_s = {1'b0, acc_q} - {1'b0, step_s};
      if (sum_s[WIDTH]) begin
        acc_next_s = {WIDTH{1'b0}};
      end else begin
        acc_next_s = sum_s[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    decim_d = decim_q;
    due_s   = 1'b0;
    if (bit_valid) begin
      acc_d = acc_next_s;
      due_s = (decim_q == DECIM_LAST);
      if (decim_q == DECIM_LAST) begin
        decim_d = {DW{1'b0}};
      end else begin
        decim_d = decim_q + DECIM_ONE;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // A drop on the same cycle as clr_ovr wins, so set is applied after clear.
  always_comb begin
    state_d       = state_q;
    sample_data_d = sample_data_q;
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      OUT_EMPTY: begin
        if (due_s) begin
          sample_data_d = acc_next_s;
          state_d       = OUT_FULL;
        end else begin
          state_d = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (sample_ready) begin
          if (due_s) begin
            sample_data_d = acc_next_s;
            state_d       = OUT_FULL;
          end else begin
            state_d = OUT_EMPTY;
          end
        end else if (due_s) begin
          overrun_d = 1'b1;
        end else begin
          state_d = OUT_FULL;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= ACC_RST;
      decim_q       <= {DW{1'b0}};
      state_q       <= OUT_EMPTY;
      sample_data_q <= {WIDTH{1'b0}};
      overrun_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      decim_q       <= decim_d;
      state_q       <= state_d;
      sample_data_q <= sample_data_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_valid = (state_q == OUT_FULL);
  assign overrun      = overrun_q;

endmodule

// File: doc/delta_decoder.md
# delta_decoder

Reconstructs a multi-bit sample stream from the 1-bit delta-modulated bitstream that the delta ADC front end produces. Each accepted bit moves an accumulator up or down by an adaptive step. Every DECIM accepted bits, the accumulator value is presented on a valid/ready output port. The block sits between the comparator-bit capture logic and the sample consumer (output pins or serializer) in the TinyTapeout top level.

## Interface
- WIDTH, 8, accumulator and sample width in bits
- STEP_MIN, 1, minimum step; power of two, ≥1
- STEP_MAX, 16, maximum step; power of two, ≤2^(WIDTH-1), ≥STEP_MIN
- RUN_LEN, 3, number of consecutive equal bits that triggers step doubling (≥2)
- DECIM, 4, accepted bits per output sample (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- bit_valid  in  1  bit_in is accepted on this cycle
- bit_in  in  1  delta bit; 1 = step up, 0 = step down
- sample_data  out  WIDTH  reconstructed sample, unsigned
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  consumer takes the sample when sample_valid & sample_ready
- overrun  out  1  sticky flag: a due sample was dropped
- clr_ovr  in  1  clears overrun

## Operation
- Reset state:
  - acc = 2^(WIDTH-1) (midscale)
  - step = STEP_MIN, last_bit = 0, run_cnt = 0, decim_cnt = 0
  - sample_data = 0, sample_valid = 0, overrun = 0
- Accumulator update on an accepted bit: acc_next = acc ± step, computed in WIDTH+1 bits, saturating to [0, 2^WIDTH−1]. The step used is the current step, before adaptation.
- Step adaptation, applied to the same accepted bit; the new step applies from the next bit:
  - bit_in == last_bit: run_cnt = min(run_cnt+1, RUN_LEN). If the new run_cnt == RUN_LEN, step = min(step·2, STEP_MAX).
  - bit_in != last_bit: run_cnt = 1, step = max(step/2, STEP_MIN).
  - last_bit = bit_in in both cases.
- Decimation: decim_cnt counts accepted bits from 0 to DECIM−1 and wraps. When the accepted bit brings the count to DECIM−1, a sample is due; its value is acc_next.
- Output FSM, states EMPTY (sample_valid=0) and FULL (sample_valid=1):
  - EMPTY, sample due → load sample_data, go to FULL.
  - FULL, handshake with no sample due → EMPTY.
  - FULL, handshake with sample due on the same cycle → load the new sample, stay FULL, no overrun.
  - FULL, no handshake, sample due → sample_data is kept, the new sample is dropped, overrun ← 1.
- overrun is sticky. clr_ovr clears it, but if a new drop occurs on the same cycle as clr_ovr, overrun stays 1.
- bit_valid=0: acc, step, run_cnt and decim_cnt hold.
- rst asserted mid-operation returns everything to reset state on the next edge. Any pending sample is discarded.

## Timing
- Bit accepted at edge t → acc, step and decim_cnt are updated after edge t.
- Due sample → sample_data and sample_valid are visible after the same edge t. Latency is 1 cycle from the final bit.
- Maximum throughput: one bit per cycle, and one sample per DECIM cycles.
- sample_data is stable while sample_valid=1 and sample_ready=0.
- No combinational path from inputs to outputs.

## Configuration
- DELTA_ADAPTIVE_EN defined: step adapts as specified above.
- DELTA_ADAPTIVE_EN undefined: step is fixed at STEP_MIN, and run_cnt/last_bit logic is not synthesized. This is plain linear delta demodulation. All other behaviour is unchanged.

## Structure
- Package delta_pkg holds:
  - output state enum (EMPTY/FULL)
  - midscale constant function
  - default parameter constants shared with the encoder side
- Sub-module delta_step_adapt holds the step/run_cnt/last_bit logic. It takes bit and accept, and outputs step. The top instantiates it only under DELTA_ADAPTIVE_EN.

## Test plan
Defaults apply unless noted (WIDTH=8, STEP_MIN=1, STEP_MAX=16, RUN_LEN=3, DECIM=4); sample_ready=1 unless noted.
- Reset, then bits 1,0,1,0 → acc goes 129,128,129,128; step stays 1; one sample = 128 after the 4th bit, valid 1 cycle later.
- Reset, then eight consecutive 1s → acc goes 129,130,131,133,137,145,161,177; samples 133 then 177; step ends at 16.
- Continuous 1s for 40 bits → acc saturates at 255 and holds; continuous 0s afterwards → saturates at 0 and never wraps.
- sample_ready=0, eight 1s → sample_data stays 133, overrun=1 after the 8th bit. Pulse clr_ovr → overrun=0. Assert clr_ovr on the same cycle as a further drop → overrun stays 1.
- sample_ready=1 on exactly the cycle the next sample is due while FULL → new sample loaded, sample_valid stays 1, overrun stays 0.
- Build without DELTA_ADAPTIVE_EN, eight 1s → samples 132 and 136. Assert rst mid-stream → all outputs return to reset values next cycle.
